// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: ALU-control decode, operand forwarding and load-use detection.
// Define ID_EX_FORWARD_EN to enable the EX/MEM and MEM/WB bypass muxes on the operands.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [1:0]        id_alu_op,
  input  logic [5:0]        id_funct,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              mem_reg_write,
  input  logic [REG_W-1:0]  mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_result,
  output logic [3:0]        alu_control,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_W-1:0]  ex_write_reg,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              load_use_hazard
);

  logic              valid_p0, reg_write_p0, mem_read_p0, mem_write_p0, mem_to_reg_p0;
  logic              alu_src_p0;
  logic [3:0]        alu_control_p0;
  logic [REG_W-1:0]  rs_p0, rt_p0, write_reg_p0;
  logic [DATA_W-1:0] rs_data_p0, rt_data_p0, imm_p0;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;

  // Unrecognised funct codes map to 1111, which the ALU treats as "output zero".
  function automatic logic [3:0] alu_decode(input logic [1:0] op, input logic [5:0] funct);
    logic [3:0] code;
    code = 4'b1111;
    case (op)
      2'b00: code = 4'b0010;
      2'b01: code = 4'b0110;
      2'b11: code = 4'b0001;
      default: begin
        case (funct)
          6'b100000: code = 4'b0010;
          6'b100010: code = 4'b0110;
          6'b100100: code = 4'b0000;
          6'b100101: code = 4'b0001;
          6'b101010: code = 4'b0111;
          6'b100111: code = 4'b1100;
          default:   code = 4'b1111;
        endcase
      end
    endcase
    return code;
  endfunction

  // EX/MEM wins over MEM/WB because it carries the younger write; r0 is never bypassed.
  function automatic logic [DATA_W-1:0] forward(
    input logic [REG_W-1:0]  src,
    input logic [DATA_W-1:0] reg_data,
    input logic              m_we,
    input logic [REG_W-1:0]  m_rd,
    input logic [DATA_W-1:0] m_res,
    input logic              w_we,
    input logic [REG_W-1:0]  w_rd,
    input logic [DATA_W-1:0] w_res
  );
    logic [DATA_W-1:0] val;
    val = reg_data;
    if (m_we && (m_rd != '0) && (m_rd == src))
      val = m_res;
    else if (w_we && (w_rd != '0) && (w_rd == src))
      val = w_res;
    return val;
  endfunction

  // ID -> EX register boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_p0       <= 1'b0;
      reg_write_p0   <= 1'b0;
      mem_read_p0    <= 1'b0;
      mem_write_p0   <= 1'b0;
      mem_to_reg_p0  <= 1'b0;
      alu_src_p0     <= 1'b0;
      alu_control_p0 <= '0;
      rs_p0          <= '0;
      rt_p0          <= '0;
      write_reg_p0   <= '0;
      rs_data_p0     <= '0;
      rt_data_p0     <= '0;
      imm_p0         <= '0;
    end else if (flush) begin
      valid_p0       <= 1'b0;
      reg_write_p0   <= 1'b0;
      mem_read_p0    <= 1'b0;
      mem_write_p0   <= 1'b0;
      mem_to_reg_p0  <= 1'b0;
      alu_src_p0     <= 1'b0;
      alu_control_p0 <= '0;
      rs_p0          <= '0;
      rt_p0          <= '0;
      write_reg_p0   <= '0;
      rs_data_p0     <= '0;
      rt_data_p0     <= '0;
      imm_p0         <= '0;
    end else if (!stall) begin
      valid_p0       <= id_valid;
      reg_write_p0   <= id_reg_write;
      mem_read_p0    <= id_mem_read;
      mem_write_p0   <= id_mem_write;
      mem_to_reg_p0  <= id_mem_to_reg;
      alu_src_p0     <= id_alu_src;
      alu_control_p0 <= alu_decode(id_alu_op, id_funct);
      rs_p0          <= id_rs;
      rt_p0          <= id_rt;
      write_reg_p0   <= id_reg_dst ? id_rd : id_rt;
      rs_data_p0     <= id_rs_data;
      rt_data_p0     <= id_rt_data;
      imm_p0         <= id_imm;
    end
  end

`ifdef ID_EX_FORWARD_EN
  always_comb begin
    fwd_rs = forward(rs_p0, rs_data_p0, mem_reg_write, mem_rd, mem_result,
                     wb_reg_write, wb_rd, wb_result);
    fwd_rt = forward(rt_p0, rt_data_p0, mem_reg_write, mem_rd, mem_result,
                     wb_reg_write, wb_rd, wb_result);
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result};

  always_comb begin
    fwd_rs = rs_data_p0;
    fwd_rt = rt_data_p0;
  end
`endif

  assign alu_control   = alu_control_p0;
  assign alu_a         = fwd_rs;
  assign alu_b         = alu_src_p0 ? imm_p0 : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ex_write_reg  = write_reg_p0;
  assign ex_valid      = valid_p0;
  assign ex_reg_write  = reg_write_p0;
  assign ex_mem_read   = mem_read_p0;
  assign ex_mem_write  = mem_write_p0;
  assign ex_mem_to_reg = mem_to_reg_p0;

  // Deliberately not gated by stall: the hazard unit keeps stalling while the load sits in EX.
  assign load_use_hazard = valid_p0 & mem_read_p0 & (rt_p0 != '0) &
                           ((rt_p0 == id_rs) | (rt_p0 == id_rt));

endmodule
